// File: rtl/serial_tx_if.sv
// serial_tx_if: parallel word handshake into the frame serializer.
// Master drives data/valid, slave returns ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: start bit, DATA_W bits LSB first, stop bit; DIV clocks per bit.
// Define SERIAL_TX_PARITY_EN to add an even parity bit before the stop bit.
module serial_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  serial_tx_if.slave  bus,
  output logic        sout,
  output logic        busy,
  output logic        done
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t              r_state;
  logic [DCW-1:0]      r_div;
  logic [BCW-1:0]      r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_sout;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [DCW-1:0]      w_div_nxt;
  logic [BCW-1:0]      w_bit_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_sout_nxt;
  logic                w_done_nxt;
  logic                w_div_end;

`ifdef SERIAL_TX_PARITY_EN
  logic                r_par;
  logic                w_par_nxt;
`endif

  assign w_div_end    = (r_div == DIV_LAST);
  assign bus.tx_ready = r_ready;
  assign sout         = r_sout;
  assign busy         = r_busy;
  assign done         = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.tx_valid && r_ready) begin
          w_state_nxt = START;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_shift_nxt = bus.tx_data;
`ifdef SERIAL_TX_PARITY_EN
          w_par_nxt   = ^bus.tx_data;
`endif
        end
      end
      START: begin
        if (w_div_end) begin
          w_state_nxt = DATA;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt   = r_div + DCW'(1);
        end
      end
      DATA: begin
        if (w_div_end) begin
          w_div_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit + BCW'(1);
          if (r_bit == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = PAR;
`else
            w_state_nxt = STOP;
`endif
          end
        end else begin
          w_div_nxt   = r_div + DCW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PAR: begin
        if (w_div_end) begin
          w_state_nxt = STOP;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt   = r_div + DCW'(1);
        end
      end
`endif
      STOP: begin
        if (w_div_end) begin
          w_state_nxt = IDLE;
          w_div_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_div_nxt   = r_div + DCW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Line level is registered from the next state so sout changes with it.
  always_comb begin
    w_sout_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_sout_nxt = 1'b0;
      DATA:    w_sout_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      PAR:     w_sout_nxt = w_par_nxt;
`endif
      default: w_sout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sout  <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_sout  <= w_sout_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

endmodule
